// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and a frame-length helper.
// Used by uart_tx_param and its benches.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Total clk cycles from accept to the Done pulse for one frame.
  function automatic int uart_frame_cycles(input int clks, input int data,
                                           input int parity, input int stop);
    return (1 + data + parity + stop) * clks;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1 while run is high and
// flags the last cycle of each serial bit with bit_end.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 39
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || restart || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_end = run && (count == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, STOP_BITS).
// Parity stage is built only when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------|-----------------------------------------------
// ST_IDLE   | line high, tx_ready=1, waiting for tx_start
// ST_START  | start bit (line low) for CLKS_PER_BIT cycles
// ST_DATA   | data bits, shreg[0] on the line, LSB first
// ST_PARITY | parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | STOP_BITS stop bits, line high; Done on exit
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 39,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] din,
  output logic                 tx_ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t          state, state_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 serial_n, active_n, done_n;
  logic                 accept, bit_end;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
  logic [DATA_BITS-1:0] din_lat, din_lat_n;
  logic                 parity_bit;
  assign parity_bit = (^din_lat) ^ PAR_ODD_BIT;
`endif

  assign tx_ready = (state == ST_IDLE) && !reset;
  assign accept   = tx_start && tx_ready;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .run    (state != ST_IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    done_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
    din_lat_n = din_lat;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          shreg_n   = din;
          bit_cnt_n = '0;
          state_n   = ST_START;
`ifdef UART_TX_PARITY_EN
          din_lat_n = din;
`endif
        end
      end
      ST_START: begin
        if (bit_end) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n   = ST_PARITY;
`else
            state_n   = ST_STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            shreg_n   = shreg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_n = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            state_n   = ST_IDLE;
            done_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Line and Active are registered from the next state so they change on the same edge as state.
    serial_n = 1'b1;
    case (state_n)
      ST_START:  serial_n = 1'b0;
      ST_DATA:   serial_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: serial_n = parity_bit;
`endif
      default:   serial_n = 1'b1;
    endcase
    active_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      din_lat     <= '0;
`endif
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      o_Tx_Serial <= serial_n;
      o_Tx_Active <= active_n;
      o_Tx_Done   <= done_n;
`ifdef UART_TX_PARITY_EN
      din_lat     <= din_lat_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three instances (8N1, 8N2, 5N1 at 2 clks/bit),
// expected frames written out by hand; parity variants apply when UART_TX_PARITY_EN is defined.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b, start_c;
  logic [7:0] din_a, din_b;
  logic [4:0] din_c;
  logic       ready_a, active_a, serial_a, done_a;
  logic       ready_b, active_b, serial_b, done_b;
  logic       ready_c, active_c, serial_c, done_c;
  logic       mon_line, mon_active, mon_done, mon_ready;
  int         sel;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  // Frames as line values per bit slot, slot 0 (start) in bit 0.
`ifdef UART_TX_PARITY_EN
  localparam int NA = 11, NB = 12, NC = 8;
  localparam logic [11:0] F_A5 = {1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [11:0] F_96 = {1'b1, 1'b0, 8'h96, 1'b0};
  localparam logic [11:0] F_5A = {1'b1, 1'b0, 8'h5A, 1'b0};
  localparam logic [11:0] F_3C = {2'b11, 1'b0, 8'h3C, 1'b0};
  localparam logic [11:0] F_C3 = {2'b11, 1'b0, 8'hC3, 1'b0};
  localparam logic [11:0] F_13 = {4'b0, 1'b1, 1'b0, 5'h13, 1'b0};
  localparam logic [11:0] F_03 = {4'b0, 1'b1, 1'b1, 5'h03, 1'b0};
`else
  localparam int NA = 10, NB = 11, NC = 7;
  localparam logic [11:0] F_A5 = {2'b0, 1'b1, 8'hA5, 1'b0};
  localparam logic [11:0] F_96 = {2'b0, 1'b1, 8'h96, 1'b0};
  localparam logic [11:0] F_5A = {2'b0, 1'b1, 8'h5A, 1'b0};
  localparam logic [11:0] F_3C = {1'b0, 2'b11, 8'h3C, 1'b0};
  localparam logic [11:0] F_C3 = {1'b0, 2'b11, 8'hC3, 1'b0};
  localparam logic [11:0] F_13 = {5'b0, 1'b1, 5'h13, 1'b0};
  localparam logic [11:0] F_03 = {5'b0, 1'b1, 5'h03, 1'b0};
`endif

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .reset(reset), .tx_start(start_a), .din(din_a), .tx_ready(ready_a),
    .o_Tx_Active(active_a), .o_Tx_Serial(serial_a), .o_Tx_Done(done_a));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_dut_b (
    .clk(clk), .reset(reset), .tx_start(start_b), .din(din_b), .tx_ready(ready_b),
    .o_Tx_Active(active_b), .o_Tx_Serial(serial_b), .o_Tx_Done(done_b));

  uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(1)) u_dut_c (
    .clk(clk), .reset(reset), .tx_start(start_c), .din(din_c), .tx_ready(ready_c),
    .o_Tx_Active(active_c), .o_Tx_Serial(serial_c), .o_Tx_Done(done_c));

  always_comb begin
    mon_line   = serial_a;
    mon_active = active_a;
    mon_done   = done_a;
    mon_ready  = ready_a;
    case (sel)
      1: begin
        mon_line = serial_b; mon_active = active_b; mon_done = done_b; mon_ready = ready_b;
      end
      2: begin
        mon_line = serial_c; mon_active = active_c; mon_done = done_c; mon_ready = ready_c;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Entered one cycle after the accept edge; leaves in the Done cycle.
  task automatic expect_frame(input string tag, input logic [11:0] bits, input int nbits,
                              input int cpb, input bit noise);
    for (int k = 0; k < nbits * cpb; k++) begin
      if (noise) begin
        if (k == 5 || k == 13 || k == 21) begin
          start_a = 1'b1;
          din_a   = 8'hFF;
        end else begin
          start_a = 1'b0;
          din_a   = 8'h00;
        end
      end
      chk({tag, "_line"}, mon_line, bits[k / cpb]);
      chk({tag, "_active"}, mon_active, 1'b1);
      chk({tag, "_nodone"}, mon_done, 1'b0);
      chk({tag, "_busy"}, mon_ready, 1'b0);
      tick();
    end
    if (noise) start_a = 1'b0;
    chk({tag, "_done"}, mon_done, 1'b1);
    chk({tag, "_end_active"}, mon_active, 1'b0);
    chk({tag, "_end_line"}, mon_line, 1'b1);
    chk({tag, "_end_ready"}, mon_ready, 1'b1);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    din_a   = '0;   din_b   = '0;   din_c   = '0;
    sel     = 0;
    repeat (3) tick();
    chk("rst_line", serial_a, 1'b1);
    chk("rst_active", active_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ready_in_reset", ready_a, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_ready_a", ready_a, 1'b1);
    chk("rst_ready_b", ready_b, 1'b1);
    chk("rst_ready_c", ready_c, 1'b1);

    // 8N1 A5, din changed right after accept
    sel = 0; din_a = 8'hA5; start_a = 1'b1;
    tick();
    start_a = 1'b0; din_a = 8'h00;
    expect_frame("t1", F_A5, NA, 4, 1'b0);
    tick();
    chk("t1_done_pulse", done_a, 1'b0);

    // tx_start pulses with din=FF while busy are ignored
    din_a = 8'h96; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    expect_frame("t5", F_96, NA, 4, 1'b1);
    tick();
    chk("t5_idle_active", active_a, 1'b0);

    // 8N2 back-to-back with tx_start held: 1-cycle gap, second word not lost
    sel = 1; din_b = 8'h3C; start_b = 1'b1;
    tick();
    din_b = 8'hC3;
    expect_frame("t3a", F_3C, NB, 4, 1'b0);
    tick();
    start_b = 1'b0;
    expect_frame("t3b", F_C3, NB, 4, 1'b0);
    tick();
    tick();
    chk("t3_idle_line", serial_b, 1'b1);
    chk("t3_idle_active", active_b, 1'b0);

    // 5-bit word at 2 clks/bit
    sel = 2; din_c = 5'h13; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    expect_frame("t6", F_13, NC, 2, 1'b0);
    tick();
    din_c = 5'h03; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    expect_frame("t6b", F_03, NC, 2, 1'b0);
    tick();

    // reset 10 clks into DATA abandons the frame
    sel = 0; din_a = 8'hA5; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (14) tick();
    chk("t4_pre_line", serial_a, 1'b1);
    chk("t4_pre_active", active_a, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t4_line", serial_a, 1'b1);
    chk("t4_active", active_a, 1'b0);
    chk("t4_ready", ready_a, 1'b1);
    chk("t4_done", done_a, 1'b0);
    for (int k = 0; k < 50; k++) begin
      chk("t4_no_done", done_a, 1'b0);
      chk("t4_quiet_line", serial_a, 1'b1);
      tick();
    end
    din_a = 8'h5A; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    expect_frame("t4_new", F_5A, NA, 4, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
